// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the fetch/sequencing stage: the fetch state
// encoding, the halt opcode and the default widths used by fetch_unit
// and its branch-target table.
// Ports: none (package).

package fetch_unit_pkg;

    // Default widths; the modules expose these as overridable parameters.
    localparam int PC_W_DEF      = 10;
    localparam int LUT_IDX_W_DEF = 5;
    localparam int CNT_W_DEF     = 16;

    // Opcode the decoder recognises as halt (drives Ack upstream of us).
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// branch_lut
// Branch-target table: 2^IDX_W entries of DATA_W-bit absolute targets.
// Cleared asynchronously by Reset, written synchronously, read
// combinationally so a branch can redirect the PC in the same cycle.
// Ports:
//   Clk, Reset  clock and asynchronous active-low clear
//   we          write enable
//   waddr       write index
//   wdata       write data (absolute target)
//   raddr       read index
//   rdata       combinational read data

module branch_lut
    import fetch_unit_pkg::*;
#(
    parameter int IDX_W  = LUT_IDX_W_DEF,
    parameter int DATA_W = PC_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [DATA_W-1:0] entries [DEPTH];

    // A write and a read of the same entry in one cycle returns the old
    // value: the new data only lands at the edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (we) begin
            entries[waddr] <= wdata;
        end
    end

    assign rdata = entries[raddr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Program counter and fetch sequencer feeding the control decoder.
// Handles the Start/Done handshake, steps or branches the PC each RUN
// cycle and counts executed RUN cycles (saturating).
// Ports:
//   Clk, Reset          clock and asynchronous active-low reset
//   Start               high arms, falling edge launches execution
//   Instruction         current machine word; low bits index the LUT
//   BranchEn, Taken     conditional branch present / condition true
//   Ack                 halt instruction present
//   LutWe, LutAddr,     branch-target table write port
//   LutData
//   ProgCtr             instruction ROM address
//   Running, Done       status flags for RUN and DONE
//   CycleCount          RUN cycles executed this program

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_IDX_W = LUT_IDX_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [8:0]           Instruction,
    input  logic                 BranchEn,
    input  logic                 Taken,
    input  logic                 Ack,
    input  logic                 LutWe,
    input  logic [LUT_IDX_W-1:0] LutAddr,
    input  logic [PC_W-1:0]      LutData,
    output logic [PC_W-1:0]      ProgCtr,
    output logic                 Running,
    output logic                 Done,
    output logic [CNT_W-1:0]     CycleCount
);

    fetch_state_t     state, nextState;
    logic [PC_W-1:0]  nextPc;
    logic [CNT_W-1:0] nextCnt;
    logic             nextRunning, nextDone;
    logic [PC_W-1:0]  lutTarget;

    // Only the low bits select a LUT entry; the opcode bits are decoded
    // elsewhere.
    logic unusedInstrBits;
    assign unusedInstrBits = ^Instruction[8:LUT_IDX_W];

    branch_lut #(
        .IDX_W  (LUT_IDX_W),
        .DATA_W (PC_W)
    ) u_lut (
        .Clk   (Clk),
        .Reset (Reset),
        .we    (LutWe),
        .waddr (LutAddr),
        .wdata (LutData),
        .raddr (Instruction[LUT_IDX_W-1:0]),
        .rdata (lutTarget)
    );

    // State register; the PC, counter and status flags are registered
    // alongside it so every output comes straight from a flop.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            ProgCtr    <= '0;
            CycleCount <= '0;
            Running    <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state      <= nextState;
            ProgCtr    <= nextPc;
            CycleCount <= nextCnt;
            Running    <= nextRunning;
            Done       <= nextDone;
        end
    end

    // Next-state: Start always wins in RUN (restart), then halt.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (Start) nextState = ARMED;
            ARMED:   if (!Start) nextState = RUN;
            RUN: begin
                if (Start)    nextState = ARMED;
                else if (Ack) nextState = DONE;
            end
            DONE:    if (Start) nextState = ARMED;
            default: nextState = IDLE;
        endcase
    end

    // Output/datapath: next PC, cycle count and flags. Entering ARMED
    // from any state zeroes the PC and the counter so a restart begins
    // at address 0 with a fresh count.
    always_comb begin
        nextPc  = ProgCtr;
        nextCnt = CycleCount;
        unique case (state)
            IDLE, ARMED: nextPc = '0;
            RUN: begin
                if (CycleCount != {CNT_W{1'b1}}) begin
                    nextCnt = CycleCount + CNT_W'(1);
                end
                // The halt edge keeps the PC pointing at the halt word.
                if (!Start && !Ack) begin
                    if (BranchEn && Taken) begin
                        nextPc = lutTarget;
                    end else begin
                        nextPc = ProgCtr + PC_W'(1);
                    end
                end
            end
            DONE: ;
            default: nextPc = '0;
        endcase
        if (nextState == ARMED) begin
            nextPc  = '0;
            nextCnt = '0;
        end
        nextRunning = (nextState == RUN);
        nextDone    = (nextState == DONE);
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch-sequencing stage directly upstream of the control decoder.
- Produces the instruction-ROM address each cycle from:
  - the decoder's BranchEn and Ack outputs;
  - the ALU branch flag.
- Owns a small branch-target lookup table (LUT) indexed by the current instruction's low bits.
- Runs the Start/Done program handshake with the testbench or host.

Parameters:
- PC_W, 10: program counter width (instruction ROM depth 2^PC_W).
- LUT_IDX_W, 5: branch-target LUT index width; index = Instruction[LUT_IDX_W-1:0].
- CNT_W, 16: width of the executed-cycle counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- Start  input  1  program request; a high level arms the unit, and the falling edge launches execution.
- Instruction  input  9  current machine code from instruction ROM (addressed by ProgCtr).
- BranchEn  input  1  from decoder: current instruction is a conditional branch.
- Taken  input  1  from ALU: branch condition true this cycle.
- Ack  input  1  from decoder: halt instruction present.
- LutWe  input  1  LUT write enable.
- LutAddr  input  LUT_IDX_W  LUT write address.
- LutData  input  PC_W  LUT write data (absolute target).
- ProgCtr  output  PC_W  instruction ROM address.
- Running  output  1  high while in RUN.
- Done  output  1  high while in DONE.
- CycleCount  output  CNT_W  RUN cycles executed this program, saturating.

Behaviour:
- Reset low (asynchronous):
  - state = IDLE; ProgCtr = 0; Running = 0; Done = 0; CycleCount = 0.
  - All LUT entries = 0.
  - Reset asserted mid-RUN aborts immediately; no residual state survives.
- States:
  - IDLE:
    - ProgCtr = 0; Done = 0.
    - Start = 1 goes to ARMED.
  - ARMED:
    - ProgCtr = 0; CycleCount = 0; Done = 0.
    - Stays while Start = 1; Start = 0 goes to RUN next edge.
    - First fetched address in RUN is 0.
  - RUN: Running = 1. Each rising edge, in priority order:
    1. Start = 1: go to ARMED (program restart); ProgCtr = 0.
    2. Ack = 1: go to DONE; ProgCtr holds its value (points at the halt instruction).
    3. BranchEn & Taken: ProgCtr = LUT[Instruction[LUT_IDX_W-1:0]].
    4. Otherwise: ProgCtr = ProgCtr + 1, modulo 2^PC_W (wraps to 0, no error).
    - CycleCount increments on every RUN edge, including the Ack edge, and saturates at 2^CNT_W-1.
  - DONE:
    - Done = 1; Running = 0; ProgCtr and CycleCount frozen.
    - Start = 1 goes to ARMED.
    - Ack/BranchEn ignored.
- Latency:
  - Branch/increment takes effect at the next edge; single-cycle fetch, no delay slot.
  - Done rises the edge after Ack is sampled in RUN.
- BranchEn with Taken = 0: plain increment. Taken alone is ignored.
- LUT:
  - Synchronous write on LutWe, accepted in any state.
  - Read is combinational.
  - Write and branch-read of the same entry in the same cycle: the branch uses the old value; the new value is visible the next cycle.
- Instruction is sampled only in RUN.
- Outputs are registered, except the LUT read path, which feeds the next-PC logic only.

Decomposition:
- Shared definitions package (definitions) holds:
  - fetch state enum: IDLE, ARMED, RUN, DONE (2-bit);
  - OP_HALT = 3'b111;
  - LUT_IDX_W and PC_W defaults.
- One natural sub-module: branch_lut.
  - Register array, 2^LUT_IDX_W x PC_W.
  - Async clear on Reset.
  - Synchronous write, combinational read.

Test Plan:
- Reset/launch:
  - Reset low 2 cycles, then high.
  - Start high 3 cycles, then low.
  - Expected: ProgCtr 0 in IDLE/ARMED, then 0,1,2,3 on successive RUN edges; Running = 1; CycleCount = 1,2,3.
- Taken branch:
  - Write LUT[5] = 10'h040.
  - In RUN at PC = 3, Instruction[4:0] = 5, BranchEn = 1, Taken = 1.
  - Expected: next ProgCtr = 0x040, then 0x041. Same stimulus with Taken = 0 gives ProgCtr = 4.
- Halt:
  - Ack = 1 at PC = 0x012.
  - Expected: next edge Done = 1, Running = 0; ProgCtr stays 0x012 for 5 further cycles; CycleCount frozen.
  - Then Start pulse: ARMED with ProgCtr = 0 and CycleCount = 0; rerun starts at 0.
- Priority:
  - Start = 1, Ack = 1, BranchEn = Taken = 1 in the same RUN cycle: go to ARMED, ProgCtr = 0.
  - Ack = 1 with branch taken: DONE, ProgCtr unchanged.
- Wrap and LUT collision:
  - PC = 10'h3FF, no branch: next ProgCtr = 0.
  - LutWe to entry 7 (data 0x100) in the same cycle as a branch via entry 7 (old value 0x020): ProgCtr = 0x020.
  - Next branch via entry 7: ProgCtr = 0x100.
- Async reset mid-run:
  - Assert Reset low between edges at PC = 0x055.
  - Expected: ProgCtr = 0, Running = 0, Done = 0 immediately (before the next edge); all LUT entries read 0.
